// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a shared 4:1 mux.
// Optional per-requester grant counters behind macro ARB_STATS_EN.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    output logic [3:0]       gnt,
    output logic [1:0]       control,
    output logic             active
`ifdef ARB_STATS_EN
    ,
    output logic [4*CNT_W-1:0] grant_count
`endif
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_d;
    logic [3:0]      gnt_d;
    logic [1:0]      control_d;
    logic [1:0]      last, last_d;
    logic [HW-1:0]   hold_cnt, hold_d;
    logic            new_grant;
    logic [1:0]      new_idx;
    logic [3:0]      others;

    // Elaboration-time guard on parameter ranges
    if (MAX_HOLD < 1 || CNT_W < 1) begin : g_param_check
        $error("mux4_rr_arbiter: MAX_HOLD and CNT_W must be >= 1");
    end

    // First requester at or after index p, wrapping mod 4
    function automatic logic [1:0] pick(input logic [1:0] p,
                                        input logic [3:0] r);
        logic [1:0] idx;
        pick = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    assign active = (state == GRANT);
    assign others = req & ~(4'b0001 << control);

    // Next-state: new grants, release to idle, hold counting
    always_comb begin
        state_d   = state;
        gnt_d     = gnt;
        control_d = control;
        last_d    = last;
        hold_d    = hold_cnt;
        new_grant = 1'b0;
        new_idx   = 2'd0;
        unique case (state)
            IDLE: begin
                gnt_d  = 4'b0000;
                hold_d = '0;
                if (req != 4'b0000) begin
                    new_grant = 1'b1;
                    new_idx   = pick(last + 2'd1, req);
                end
            end
            GRANT: begin
                if (!req[control]) begin
                    if (req != 4'b0000) begin
                        new_grant = 1'b1;
                        new_idx   = pick(control + 2'd1, req);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        hold_d  = '0;
                    end
                end else if (hold_cnt == HW'(MAX_HOLD)
                             && others != 4'b0000) begin
                    new_grant = 1'b1;
                    new_idx   = pick(control + 2'd1, req);
                end else if (hold_cnt != HW'(MAX_HOLD)) begin
                    hold_d = hold_cnt + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (new_grant) begin
            state_d   = GRANT;
            gnt_d     = 4'b0001 << new_idx;
            control_d = new_idx;
            last_d    = new_idx;
            hold_d    = HW'(1);
        end
    end

    // Arbitration state; last starts at 3 so requester 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            control  <= 2'd0;
            last     <= 2'd3;
            hold_cnt <= '0;
        end else begin
            state    <= state_d;
            gnt      <= gnt_d;
            control  <= control_d;
            last     <= last_d;
            hold_cnt <= hold_d;
        end
    end

`ifdef ARB_STATS_EN
    // Saturating count of grants newly issued to each requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count <= '0;
        end else if (new_grant) begin
            if (grant_count[new_idx*CNT_W +: CNT_W] != {CNT_W{1'b1}})
                grant_count[new_idx*CNT_W +: CNT_W] <=
                    grant_count[new_idx*CNT_W +: CNT_W] + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter against a rule-level model.
// Stats checks are compiled in when ARB_STATS_EN is defined.
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] control;
    logic       active;
`ifdef ARB_STATS_EN
    logic [4*CNT_W-1:0] grant_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: holder index (-1 = none), last holder, run length
    int m_hold;
    int m_last;
    int m_ctrl;
    int m_run;
    int m_cnt [4];

    logic [7:0] mux_in [4];
    logic [7:0] mux_y;

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .gnt(gnt),
        .control(control),
        .active(active)
`ifdef ARB_STATS_EN
        ,
        .grant_count(grant_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mux_y = mux_in[control];

    function automatic int m_pick(input int p, input logic [3:0] r);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic void m_reset();
        m_hold = -1;
        m_last = 3;
        m_ctrl = 0;
        m_run  = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endfunction

    function automatic void m_grant(input int i);
        m_hold = i;
        m_last = i;
        m_ctrl = i;
        m_run  = 1;
        if (m_cnt[i] < (1 << CNT_W) - 1) m_cnt[i]++;
    endfunction

    function automatic void m_step(input logic [3:0] r);
        if (m_hold < 0) begin
            if (r != 0) m_grant(m_pick(m_last + 1, r));
        end else if (!r[m_hold]) begin
            if (r != 0) m_grant(m_pick(m_hold + 1, r));
            else m_hold = -1;
        end else if (m_run >= MAX_HOLD && (r & ~(4'b1 << m_hold)) != 0) begin
            m_grant(m_pick(m_hold + 1, r));
        end else begin
            m_run++;
        end
    endfunction

    function automatic logic [3:0] m_gnt();
        return (m_hold < 0) ? 4'b0000 : (4'b0001 << m_hold);
    endfunction

    task automatic tick();
        @(posedge clk);
        m_step(req);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req   = 4'b1111;
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #3;
        n_cmp++;
        if (gnt !== 4'b0000) begin
            n_bad++; $display("FAIL reset_gnt got %b want 0000", gnt);
        end
        n_cmp++;
        if (control !== 2'd0) begin
            n_bad++; $display("FAIL reset_control got %0d want 0", control);
        end
        n_cmp++;
        if (active !== 1'b0) begin
            n_bad++; $display("FAIL reset_active got %b want 0", active);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001 || control !== 2'd0 || active !== 1'b1) begin
            n_bad++;
            $display("FAIL first_grant got %b/%0d/%b want 0001/0/1",
                     gnt, control, active);
        end
    endtask

    task automatic test_single();
        req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_cmp++;
            if (gnt !== 4'b0100 || control !== 2'd2) begin
                n_bad++;
                $display("FAIL single c=%0d got %b/%0d want 0100/2",
                         c, gnt, control);
            end
        end
        req = 4'b0000;
        tick();
        n_cmp++;
        if (gnt !== 4'b0000 || active !== 1'b0 || control !== 2'd2) begin
            n_bad++;
            $display("FAIL single_drop got %b/%b/%0d want 0000/0/2",
                     gnt, active, control);
        end
    endtask

    task automatic test_contention();
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            tick();
            n_cmp++;
            if (control !== 2'((c / MAX_HOLD) % 4)
                || mux_y !== mux_in[(c / MAX_HOLD) % 4]) begin
                n_bad++;
                $display("FAIL contention c=%0d got sel %0d y %h want sel %0d",
                         c, control, mux_y, (c / MAX_HOLD) % 4);
            end
        end
    endtask

    task automatic test_handoff();
        logic [3:0] rq [4];
        logic [3:0] ex [4];
        rq = '{4'b0001, 4'b1010, 4'b1000, 4'b0001};
        ex = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        do_reset();
        for (int s = 0; s < 4; s++) begin
            req = rq[s];
            tick();
            n_cmp++;
            if (gnt !== ex[s] || active !== 1'b1) begin
                n_bad++;
                $display("FAIL handoff s=%0d got %b/%b want %b/1",
                         s, gnt, active, ex[s]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0100;
        repeat (5) tick();
        n_cmp++;
        if (gnt !== 4'b0100) begin
            n_bad++; $display("FAIL async_pre got %b want 0100", gnt);
        end
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        n_cmp++;
        if (gnt !== 4'b0000 || active !== 1'b0) begin
            n_bad++;
            $display("FAIL async_clear got %b/%b want 0000/0", gnt, active);
        end
        req = 4'b0110;
        #1;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_bad++; $display("FAIL async_rearb got %b want 0010", gnt);
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_g;
        do_reset();
        req = 4'($urandom);
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3) == 0) req = 4'($urandom);
            tick();
            exp_g = m_gnt();
            n_cmp++;
            if (gnt !== exp_g || control !== 2'(m_ctrl)
                || active !== (m_hold >= 0)) begin
                n_bad++;
                $display("FAIL random c=%0d req %b got %b/%0d/%b want %b/%0d/%b",
                         c, req, gnt, control, active,
                         exp_g, m_ctrl, m_hold >= 0);
            end
            n_cmp++;
            if ($countones(gnt) > 1 || (active && !gnt[control])) begin
                n_bad++;
                $display("FAIL invariant c=%0d got gnt %b sel %0d want onehot",
                         c, gnt, control);
            end
`ifdef ARB_STATS_EN
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (grant_count[i*CNT_W +: CNT_W] !== CNT_W'(m_cnt[i])) begin
                    n_bad++;
                    $display("FAIL stats_rand c=%0d i=%0d got %0d want %0d",
                             c, i, grant_count[i*CNT_W +: CNT_W], m_cnt[i]);
                end
            end
`endif
        end
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        req = 4'b0011;
        repeat (32) tick();
        n_cmp++;
        if (grant_count[0 +: CNT_W] !== CNT_W'(2)
            || grant_count[CNT_W +: CNT_W] !== CNT_W'(2)) begin
            n_bad++;
            $display("FAIL stats got %0d/%0d want 2/2",
                     grant_count[0 +: CNT_W], grant_count[CNT_W +: CNT_W]);
        end
    endtask
`endif

    initial begin
        mux_in = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        rst_n  = 1'b0;
        req    = 4'b0000;
        m_reset();
        test_reset();
        test_single();
        test_contention();
        test_handoff();
        test_async_reset();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 mux datapath between four requesters.
- Drives the mux's 2-bit `control` select from a registered grant, so select changes only on clock edges.
- Sits directly in front of `mux4`: requester i owns mux input i (A=0, B=1, C=2, D=3) while granted.
- A hold limit stops one requester monopolising the mux under contention.

Parameters:
- MAX_HOLD, 8: max consecutive grant cycles for one holder while another requester is pending; legal range ≥1.
- CNT_W, 8: width of each per-requester grant counter (only used with ARB_STATS_EN).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request per requester; held high for as long as the mux is wanted.
- gnt  output  4  one-hot registered grant; all zero when idle.
- control  output  2  mux select = index of the current or last holder; connects to mux4 control.
- active  output  1  high while any grant is held.
- grant_count  output  4*CNT_W  per-requester grant counts, requester i at bits [i*CNT_W +: CNT_W]; present only with ARB_STATS_EN.

Behaviour:
- Reset: asserting rst_n low clears state immediately, without a clock edge.
  - gnt=0, control=0, active=0, state=IDLE, hold_cnt=0.
  - Internal last-holder pointer = 3, so requester 0 has first priority after reset.
- Round-robin pick, starting from index p: first i in p, p+1, p+2, p+3 (mod 4) with req[i]=1.
- hold_cnt width is clog2(MAX_HOLD+1). It saturates at MAX_HOLD.
- IDLE state:
  - If req≠0 at an edge: grant pick(last+1). After that edge, gnt=onehot(i), control=i, active=1, hold_cnt=1, last=i, state=GRANT.
  - Latency from req to gnt is 1 cycle.
  - If req=0: stay in IDLE. gnt=0, active=0, control keeps its previous value.
- GRANT state, holder g:
  - Release, req[g]=0 at an edge:
    - Other requests pending: grant pick(g+1) at the same edge (no idle bubble), hold_cnt=1.
    - None pending: go to IDLE with gnt=0, active=0; control holds g.
  - Preempt, req[g]=1, hold_cnt==MAX_HOLD, and another req pending: grant pick(g+1) at that edge, hold_cnt=1.
  - Otherwise req[g]=1: keep the grant and increment hold_cnt (saturating). A lone requester is never preempted.
- Every new grant (from IDLE, release hand-off or preempt) sets last to the new index.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt[control]=1 whenever active=1.
  - control never changes while the same holder keeps its grant.
- With all four requesting continuously, each holder keeps the mux for exactly MAX_HOLD cycles, in order 0,1,2,3,0,…
- MAX_HOLD=1: under contention the grant rotates every cycle.
- Requests that assert and drop between edges are not seen; only sampled values matter.
- Reset mid-grant: outputs clear asynchronously. After rst_n deasserts, arbitration restarts at requester 0.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds the grant_count port and four CNT_W-bit counters.
  - Counter i increments by 1 on each edge where a new grant to i is issued. A continued hold does not count; a re-grant after a release does.
  - Counters saturate at all-ones and clear on rst_n.
- Undefined: no grant_count port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 → gnt=0, control=0, active=0. Release rst_n → after the first edge, gnt=4'b0001, control=0, active=1.
- Single requester: req=4'b0100 for 20 cycles → gnt=4'b0100 and control=2 throughout, no preemption. Drop req → next edge gnt=0, active=0, control stays 2.
- Full contention, MAX_HOLD=8: req=4'b1111 held → control sequence 0,1,2,3,0, each value held exactly 8 cycles. The mux output follows A, B, C, D in turn.
- Release hand-off: holder 0 granted, req goes 4'b0001→4'b1010 → next edge gnt=4'b0010 (no idle cycle). Then req=4'b1000 → gnt=4'b1000. Then req=4'b0001 → gnt=4'b0001, i.e. wrap-around from 3.
- Async reset mid-grant: gnt=4'b0100 with hold_cnt=5, pulse rst_n low between edges → gnt=0 and active=0 immediately, with no clock edge. Re-arbitration with req=4'b0110 grants 1 first.
- ARB_STATS_EN: req=4'b0011 for 32 cycles with MAX_HOLD=8 → grant_count shows 2 for requester 0 and 2 for requester 1. Saturation test with CNT_W=2 → counter holds at 3.
